// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg: shared word size, bubble word and stage-register state encoding
package pipe_skid_reg_pkg;
  localparam int WORD_SIZE = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  typedef enum logic [1:0] {
    PSR_EMPTY = 2'b00,
    PSR_FULL1 = 2'b01,
    PSR_FULL2 = 2'b11
  } psr_state_e;
endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage register with two-entry skid buffer and flush-to-bubble
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(NOP_WORD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  psr_state_e r_state, w_next;
  logic [WIDTH-1:0] r_main, r_skid;
  logic w_in_fire, w_out_fire;
  assign in_ready = ~r_state[1] & rst;
  assign out_valid = r_state[0];
  assign out_data = r_main;
  assign w_in_fire = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  always_comb begin
    w_next = r_state;
    w_next = r_state == PSR_EMPTY ? (w_in_fire ? PSR_FULL1 : PSR_EMPTY)
           : r_state == PSR_FULL1 ? (w_in_fire && !w_out_fire ? PSR_FULL2
                                   : !w_in_fire && w_out_fire ? PSR_EMPTY : PSR_FULL1)
           : (w_out_fire ? PSR_FULL1 : PSR_FULL2);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= PSR_EMPTY;
      r_main <= RESET_VAL;
    end else if (flush) begin
      r_state <= PSR_EMPTY;
      r_main <= BUBBLE_VAL;
    end else begin
      r_state <= w_next;
      if (w_in_fire && (!r_state[0] || w_out_fire)) r_main <= in_data;
      else if (r_state[1] && w_out_fire) r_main <= r_skid;
    end
  end
  always_ff @(posedge clk) begin
    if (w_in_fire && r_state[0] && !w_out_fire) r_skid <= in_data;
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: queue-model scoreboard bench with directed scenarios and randomized handshakes
module tb_pipe_skid_reg;
  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'hFF;
  localparam logic [W-1:0] BV = 8'h00;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  int n_cmp = 0, n_bad = 0, n_words = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] last;
  bit started = 0;
  string phase = "reset";
  pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV), .BUBBLE_VAL(BV)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    bit of, inf;
    of = q.size() > 0 && out_ready;
    inf = q.size() < 2 && in_valid;
    if (!rst) begin
      q.delete();
      last = RV;
      started = 1;
    end else if (flush) begin
      q.delete();
      last = BV;
    end else begin
      if (of) begin
        last = q.pop_front();
        n_words++;
      end
      if (inf) q.push_back(in_data);
    end
  end
  task automatic check(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %h expected %h", phase, nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (started) begin
      check("in_ready", W'(in_ready), W'(rst && q.size() < 2));
      check("out_valid", W'(out_valid), W'(q.size() > 0));
      check("out_data", out_data, q.size() > 0 ? q[0] : last);
    end
  end
  task automatic step(bit v, logic [W-1:0] d, bit r, bit f = 0, bit rs = 1);
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
    rst = rs;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    phase = "stream";
    step(1, 8'h11, 1);
    step(1, 8'h22, 1);
    step(1, 8'h33, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    phase = "skid";
    step(1, 8'h0A, 0);
    step(1, 8'h0B, 0);
    repeat (3) step(0, 0, 0);
    repeat (3) step(0, 0, 1);
    phase = "flush";
    step(1, 8'h0A, 0);
    step(1, 8'h0B, 0);
    step(1, 8'h0C, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    phase = "simul";
    step(1, 8'h05, 0);
    step(1, 8'h06, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    phase = "midrst";
    step(1, 8'h07, 0);
    step(1, 8'h08, 0);
    step(0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 1);
    phase = "random";
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 499) != 0);
    phase = "drain";
    repeat (4) step(0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
